voice_allocator: RTL

Polyphony controller that sits between the note-event source (MIDI decoder) and a bank of NUM_VOICES oscillator/envelope voice slices. Each accepted note-on/note-off event is mapped to one voice. The block drives that voice's envelope `play` gate and note number. When no voice is free it steals one: releasing voices are preferred over held voices, and the oldest voice is preferred within each class.

---
 rtl/voice_allocator.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/voice_allocator.sv
// voice_allocator: polyphony controller mapping note events onto NUM_VOICES voice slices.
// A note-on is given to the lowest-index free voice; failing that, the oldest releasing voice;
// failing that, the oldest held voice is stolen, with its gate dropped for RETRIG_GAP cycles.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   note_valid    event present;  note_ready  event can be accepted (IDLE only)
//   note_on       1 = note-on, 0 = note-off;  note_num  event note number
//   voice_active  per voice: envelope still sounding
//   voice_play    per-voice envelope gate;  voice_note  per-voice note, voice i at [i*NOTE_WIDTH +:]
//   alloc_valid   one-cycle pulse on a note-on commit
//   alloc_voice   index of the last committed voice;  alloc_stole  commit stole a held voice
module voice_allocator #(
   parameter int unsigned NUM_VOICES = 8,
   parameter int unsigned NOTE_WIDTH = 7,
   parameter int unsigned AGE_WIDTH  = 16,
   parameter int unsigned RETRIG_GAP = 2,
   localparam int unsigned IDX_W     = $clog2(NUM_VOICES),
   localparam int unsigned GAP_W     = $clog2(RETRIG_GAP + 1)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             note_valid,
   output logic                             note_ready,
   input  logic                             note_on,
   input  logic [NOTE_WIDTH-1:0]            note_num,
   input  logic [NUM_VOICES-1:0]            voice_active,
   output logic [NUM_VOICES-1:0]            voice_play,
   output logic [NUM_VOICES*NOTE_WIDTH-1:0] voice_note,
   output logic                             alloc_valid,
   output logic [IDX_W-1:0]                 alloc_voice,
   output logic                             alloc_stole
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(RETRIG_GAP - 1);

   typedef enum logic [2:0] {StIdle, StScan, StDecide, StGap, StOff} state_t;

   state_t state, state_next;

   logic [IDX_W-1:0]      scan_idx;
   logic                  cand_valid;
   logic [IDX_W-1:0]      cand_idx;
   logic [1:0]            cand_class;   // 0 free, 1 releasing, 2 held
   logic [AGE_WIDTH-1:0]  cand_age;
   logic [NOTE_WIDTH-1:0] ev_note;
   logic [GAP_W-1:0]      gap_cnt;
   logic [AGE_WIDTH-1:0]  age [NUM_VOICES];

   logic       dup_hit;
   logic [1:0] scan_class;
   logic       scan_replace;
   logic       accept;
   logic       start_scan;
   logic       steal_start;
   logic       commit;
   logic       commit_steal;

   // A note-on whose note is already gated on some voice is dropped.
   always_comb begin
      dup_hit = 1'b0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
         if (voice_play[i] && (voice_note[i*NOTE_WIDTH +: NOTE_WIDTH] == note_num)) begin
            dup_hit = 1'b1;
         end
      end
   end

   // Classify the voice under scan and decide whether it beats the current candidate.
   always_comb begin
      scan_class = 2'd0;
      if (voice_play[scan_idx]) begin
         scan_class = 2'd2;
      end else if (voice_active[scan_idx]) begin
         scan_class = 2'd1;
      end
      scan_replace = !cand_valid || (scan_class < cand_class) ||
                     ((scan_class == cand_class) && (scan_class != 2'd0) &&
                      (age[scan_idx] > cand_age));
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= StIdle;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      unique case (state)
         StIdle: begin
            if (note_valid) begin
               if (!note_on) begin
                  state_next = StOff;
               end else if (!dup_hit) begin
                  state_next = StScan;
               end
            end
         end
         StScan:   if (scan_idx == LAST_IDX) state_next = StDecide;
         StDecide: state_next = (cand_class == 2'd2) ? StGap : StIdle;
         StGap:    if (gap_cnt == GAP_LAST) state_next = StIdle;
         StOff:    state_next = StIdle;
         default:  state_next = StIdle;
      endcase
   end

   // Output / control decode
   always_comb begin
      note_ready   = (state == StIdle);
      accept       = note_valid && note_ready;
      start_scan   = accept && note_on && !dup_hit;
      steal_start  = (state == StDecide) && (cand_class == 2'd2);
      commit_steal = (state == StGap) && (gap_cnt == GAP_LAST);
      commit       = ((state == StDecide) && (cand_class != 2'd2)) || commit_steal;
   end

   // Datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         scan_idx    <= '0;
         cand_valid  <= 1'b0;
         cand_idx    <= '0;
         cand_class  <= 2'd0;
         cand_age    <= '0;
         ev_note     <= '0;
         gap_cnt     <= '0;
         voice_play  <= '0;
         voice_note  <= '0;
         alloc_valid <= 1'b0;
         alloc_voice <= '0;
         alloc_stole <= 1'b0;
         for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            age[i] <= '0;
         end
      end else begin
         alloc_valid <= commit;
         alloc_stole <= commit_steal;
         if (commit) begin
            alloc_voice <= cand_idx;
         end

         if (accept) begin
            ev_note <= note_num;
         end

         if (start_scan) begin
            scan_idx   <= '0;
            cand_valid <= 1'b0;
         end else if (state == StScan) begin
            if (scan_idx != LAST_IDX) begin
               scan_idx <= scan_idx + 1'b1;
            end
            if (scan_replace) begin
               cand_valid <= 1'b1;
               cand_idx   <= scan_idx;
               cand_class <= scan_class;
               cand_age   <= age[scan_idx];
            end
         end

         if (steal_start) begin
            gap_cnt <= '0;
         end else if (state == StGap) begin
            gap_cnt <= gap_cnt + 1'b1;
         end

         for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            if (age[i] != '1) begin
               age[i] <= age[i] + 1'b1;
            end
         end
         // Later assignment overrides the increment for the committed voice.
         if (commit) begin
            age[cand_idx] <= '0;
         end

         if (state == StDecide) begin
            voice_note[cand_idx*NOTE_WIDTH +: NOTE_WIDTH] <= ev_note;
         end
         if (steal_start) begin
            voice_play[cand_idx] <= 1'b0;
         end
         if (commit) begin
            voice_play[cand_idx] <= 1'b1;
         end

         if (state == StOff) begin
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
               if (voice_play[i] && (voice_note[i*NOTE_WIDTH +: NOTE_WIDTH] == ev_note)) begin
                  voice_play[i] <= 1'b0;
               end
            end
         end
      end
   end

endmodule
